// File: rtl/ama_riscv_fe_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ama_riscv_fe_ctrl_pkg
// Shared types and constants for the frontend sequencer and its consumers.
//   fe_state_t       - frontend sequencer states
//   pc_sel_t         - PC source select seen by the PC register mux
//   fe_ctrl_t        - {pc_sel, pc_we} request bundle (decoder -> PC logic)
//   FE_CTRL_INIT_VAL - request value driven while the core is in reset
//   is_ctrl_xfer()   - true when ID holds a branch/JALR that needs EX
// ----------------------------------------------------------------------------
package ama_riscv_fe_ctrl_pkg;

    localparam int PERF_CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        FE_START    = 2'd0,
        FE_RUN      = 2'd1,
        FE_WAIT_RES = 2'd2,
        FE_REDIRECT = 2'd3
    } fe_state_t;

    typedef enum logic [1:0] {
        PC_SEL_START_ADDR = 2'd0,
        PC_SEL_INC4       = 2'd1,
        PC_SEL_ALU        = 2'd2,
        PC_SEL_JAL_BP     = 2'd3
    } pc_sel_t;

    typedef struct packed {
        pc_sel_t pc_sel;
        logic    pc_we;
    } fe_ctrl_t;

    localparam fe_ctrl_t FE_CTRL_INIT_VAL = '{pc_sel: PC_SEL_START_ADDR, pc_we: 1'b0};

    // A bubble in ID carries stale itype bits, so valid qualifies both flags.
    function automatic logic is_ctrl_xfer(input logic valid, input logic branch,
                                          input logic jalr);
        return valid & (branch | jalr);
    endfunction

endpackage

// File: rtl/ama_riscv_perf_cnt.sv
// ----------------------------------------------------------------------------
// ama_riscv_perf_cnt
// Free-running event counter: +1 on every clock where en=1, wraps to 0.
// Ports:
//   clk  in   core clock
//   rst  in   asynchronous active-high reset, clears the count
//   en   in   event strobe for this cycle
//   cnt  out  current count, PERF_CNT_W bits
// ----------------------------------------------------------------------------
module ama_riscv_perf_cnt #(
    parameter int PERF_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [PERF_CNT_W-1:0] cnt
);

    logic [PERF_CNT_W-1:0] cnt_q;
    logic [PERF_CNT_W-1:0] cnt_d;

    // Natural modulo-2^W wrap from the unsigned add.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = cnt_q + {{(PERF_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ama_riscv_fe_ctrl.sv
// ----------------------------------------------------------------------------
// ama_riscv_fe_ctrl
// Frontend sequencer between the ID-stage decoder and the PC/IMEM logic.
// Passes the decoder request through while the frontend can progress and
// overrides it for the post-reset start fetch, branch/JALR resolution,
// backend stalls and IMEM back-pressure. Also counts ID bubbles.
// Ports:
//   clk, rst      core clock, asynchronous active-high reset
//   dec_valid     ID holds a valid instruction
//   dec_fe_ctrl   decoder frontend request
//   dec_branch    ID instruction is a branch
//   dec_jalr      ID instruction is a JALR
//   ex_res_valid  EX resolves the outstanding branch/JALR this cycle
//   ex_res_taken  branch outcome (JALR always redirects)
//   be_stall      backend stall, freezes the frontend
//   imem_ready    IMEM accepts a new fetch address this cycle
//   fe_ctrl       final pc_sel/pc_we to the PC register
//   id_bubble     turn the instruction entering ID into a NOP
//   bubble_cnt    number of cycles with id_bubble=1
// ----------------------------------------------------------------------------
module ama_riscv_fe_ctrl
    import ama_riscv_fe_ctrl_pkg::*;
#(
    parameter int PERF_CNT_W = PERF_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dec_valid,
    input  fe_ctrl_t              dec_fe_ctrl,
    input  logic                  dec_branch,
    input  logic                  dec_jalr,
    input  logic                  ex_res_valid,
    input  logic                  ex_res_taken,
    input  logic                  be_stall,
    input  logic                  imem_ready,
    output fe_ctrl_t              fe_ctrl,
    output logic                  id_bubble,
    output logic [PERF_CNT_W-1:0] bubble_cnt
);

    fe_state_t state_q, state_d;
    logic      jalr_flag_q, jalr_flag_d;
    logic      redir_q, redir_d;

    fe_ctrl_t  fsm_ctrl;
    logic      fsm_bubble;
    logic      can_adv;

    // ------------------------------------------------------------------
    // Next state and the per-state (pre-override) frontend request.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        jalr_flag_d = jalr_flag_q;
        redir_d     = redir_q;
        fsm_ctrl    = FE_CTRL_INIT_VAL;
        fsm_bubble  = 1'b1;
        // Stall and IMEM back-pressure both freeze progress.
        can_adv     = imem_ready & ~be_stall;

        case (state_q)
            FE_START: begin
                fsm_ctrl.pc_sel = PC_SEL_START_ADDR;
                fsm_ctrl.pc_we  = 1'b1;
                fsm_bubble      = 1'b1;
                if (can_adv) begin
                    state_d = FE_RUN;
                end
            end

            FE_RUN: begin
                // Zero-latency pass-through; the decoder already drops pc_we
                // for the branch/JALR itself.
                fsm_ctrl   = dec_fe_ctrl;
                fsm_bubble = 1'b0;
                if (can_adv && is_ctrl_xfer(dec_valid, dec_branch, dec_jalr)) begin
                    state_d     = FE_WAIT_RES;
                    jalr_flag_d = dec_jalr;
                end
            end

            FE_WAIT_RES: begin
                fsm_ctrl.pc_sel = PC_SEL_INC4;
                fsm_ctrl.pc_we  = 1'b0;
                fsm_bubble      = 1'b1;
                // Capture is not gated by stall or IMEM: EX reports the
                // outcome exactly once and it must not be dropped.
                if (ex_res_valid) begin
                    redir_d = jalr_flag_q | ex_res_taken;
                    state_d = FE_REDIRECT;
                end
            end

            FE_REDIRECT: begin
                fsm_ctrl.pc_sel = redir_q ? PC_SEL_ALU : PC_SEL_INC4;
                fsm_ctrl.pc_we  = 1'b1;
                fsm_bubble      = 1'b1;
                // Leave only on the cycle the redirect PC is actually written.
                if (can_adv) begin
                    state_d = FE_RUN;
                end
            end

            default: begin
                state_d = FE_START;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Global override mux: rst > be_stall > !imem_ready > FSM.
    // rst is decoded here as well so the outputs show the init value while
    // reset is held, not only after the first edge.
    // ------------------------------------------------------------------
    always_comb begin
        fe_ctrl   = fsm_ctrl;
        id_bubble = fsm_bubble;
        if (rst) begin
            fe_ctrl   = FE_CTRL_INIT_VAL;
            id_bubble = 1'b1;
        end else if (be_stall) begin
            fe_ctrl.pc_we = 1'b0;
            // The instruction in ID is frozen, not replaced.
            id_bubble     = 1'b0;
        end else if (!imem_ready) begin
            fe_ctrl.pc_we = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FE_START;
            jalr_flag_q <= 1'b0;
            redir_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            jalr_flag_q <= jalr_flag_d;
            redir_q     <= redir_d;
        end
    end

    ama_riscv_perf_cnt #(
        .PERF_CNT_W (PERF_CNT_W)
    ) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .en  (id_bubble),
        .cnt (bubble_cnt)
    );

    // A resolution with nothing outstanding means EX and ID disagree about
    // the pipeline contents; the FSM ignores it.
    ex_res_only_in_wait_res: assert property (
        @(posedge clk) disable iff (rst)
        ex_res_valid |-> (state_q == FE_WAIT_RES)
    );

endmodule

// File: tb/tb_ama_riscv_fe_ctrl.sv
module tb_ama_riscv_fe_ctrl;
    import ama_riscv_fe_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        dec_valid;
    fe_ctrl_t    dec_fe_ctrl;
    logic        dec_branch;
    logic        dec_jalr;
    logic        ex_res_valid;
    logic        ex_res_taken;
    logic        be_stall;
    logic        imem_ready;
    fe_ctrl_t    fe_ctrl;
    logic        id_bubble;
    logic [31:0] bubble_cnt;

    logic [2:0]  fe_obs;
    int          passed;
    int          total;
    int          exp_bc;

    // {pc_sel, pc_we} encodings
    localparam logic [2:0] C_INIT      = 3'b000;
    localparam logic [2:0] C_START_WE  = 3'b001;
    localparam logic [2:0] C_INC4_NOWE = 3'b010;
    localparam logic [2:0] C_INC4_WE   = 3'b011;
    localparam logic [2:0] C_ALU_NOWE  = 3'b100;
    localparam logic [2:0] C_ALU_WE    = 3'b101;
    localparam logic [2:0] C_JAL_WE    = 3'b111;

    assign fe_obs = fe_ctrl;

    ama_riscv_fe_ctrl #(.PERF_CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .dec_valid    (dec_valid),
        .dec_fe_ctrl  (dec_fe_ctrl),
        .dec_branch   (dec_branch),
        .dec_jalr     (dec_jalr),
        .ex_res_valid (ex_res_valid),
        .ex_res_taken (ex_res_taken),
        .be_stall     (be_stall),
        .imem_ready   (imem_ready),
        .fe_ctrl      (fe_ctrl),
        .id_bubble    (id_bubble),
        .bubble_cnt   (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic v, input logic br, input logic jr, input logic [2:0] req);
        dec_valid   = v;
        dec_branch  = br;
        dec_jalr    = jr;
        dec_fe_ctrl = req;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ready = 1'b1; be_stall = 1'b0;
        ex_res_valid = 1'b0; ex_res_taken = 1'b0;
        set_dec(1'b0, 1'b0, 1'b0, C_INIT);
        tick(); tick();
        total++; if (fe_obs !== C_INIT) $display("FAIL reset_fe_ctrl: got %0h exp %0h", fe_obs, C_INIT); else passed++;
        total++; if (id_bubble !== 1'b1) $display("FAIL reset_bubble: got %0b exp 1", id_bubble); else passed++;
        total++; if (bubble_cnt !== 32'd0) $display("FAIL reset_cnt: got %0d exp 0", bubble_cnt); else passed++;
        rst = 1'b0;
        #1;
        total++; if (fe_obs !== C_START_WE) $display("FAIL start_fe_ctrl: got %0h exp %0h", fe_obs, C_START_WE); else passed++;
        total++; if (id_bubble !== 1'b1) $display("FAIL start_bubble: got %0b exp 1", id_bubble); else passed++;
        tick();
        set_dec(1'b1, 1'b0, 1'b0, C_INC4_WE);
        #1;
        total++; if (fe_obs !== C_INC4_WE) $display("FAIL run_pass_inc4: got %0h exp %0h", fe_obs, C_INC4_WE); else passed++;
        total++; if (id_bubble !== 1'b0) $display("FAIL run_bubble: got %0b exp 0", id_bubble); else passed++;
        exp_bc = 1;
        total++; if (bubble_cnt !== 32'(exp_bc)) $display("FAIL start_cnt: got %0d exp %0d", bubble_cnt, exp_bc); else passed++;
        set_dec(1'b1, 1'b0, 1'b0, C_JAL_WE);
        #1;
        total++; if (fe_obs !== C_JAL_WE) $display("FAIL run_pass_jal: got %0h exp %0h", fe_obs, C_JAL_WE); else passed++;
        // A bubble with stale branch bits must not start a wait.
        set_dec(1'b0, 1'b1, 1'b0, C_INC4_WE);
        tick();
        #1;
        total++; if (id_bubble !== 1'b0 || fe_obs !== C_INC4_WE) $display("FAIL invalid_branch_ignored: got bub=%0b fe=%0h exp bub=0 fe=%0h", id_bubble, fe_obs, C_INC4_WE); else passed++;
        $display("test_reset done, bubble_cnt=%0d", bubble_cnt);
    endtask

    task automatic test_branch_not_taken();
        set_dec(1'b1, 1'b1, 1'b0, C_INC4_NOWE);
        #1;
        total++; if (fe_obs !== C_INC4_NOWE) $display("FAIL br_id_fe_ctrl: got %0h exp %0h", fe_obs, C_INC4_NOWE); else passed++;
        tick();
        set_dec(1'b1, 1'b0, 1'b0, C_INC4_WE);
        ex_res_valid = 1'b1; ex_res_taken = 1'b0;
        #1;
        total++; if (fe_obs[0] !== 1'b0) $display("FAIL br_wait_pc_we: got %0b exp 0", fe_obs[0]); else passed++;
        total++; if (id_bubble !== 1'b1) $display("FAIL br_wait_bubble: got %0b exp 1", id_bubble); else passed++;
        tick();
        ex_res_valid = 1'b0;
        #1;
        total++; if (fe_obs !== C_INC4_WE) $display("FAIL br_redirect: got %0h exp %0h", fe_obs, C_INC4_WE); else passed++;
        total++; if (id_bubble !== 1'b1) $display("FAIL br_redirect_bubble: got %0b exp 1", id_bubble); else passed++;
        tick();
        set_dec(1'b1, 1'b0, 1'b0, C_JAL_WE);
        #1;
        exp_bc += 2;
        total++; if (fe_obs !== C_JAL_WE || id_bubble !== 1'b0) $display("FAIL br_back_to_run: got fe=%0h bub=%0b exp fe=%0h bub=0", fe_obs, id_bubble, C_JAL_WE); else passed++;
        total++; if (bubble_cnt !== 32'(exp_bc)) $display("FAIL br_cnt: got %0d exp %0d", bubble_cnt, exp_bc); else passed++;
        $display("test_branch_not_taken done, bubble_cnt=%0d", bubble_cnt);
    endtask

    task automatic test_jalr();
        set_dec(1'b1, 1'b0, 1'b1, C_INC4_NOWE);
        tick();
        set_dec(1'b1, 1'b0, 1'b0, C_INC4_WE);
        for (int c = 0; c < 3; c++) begin
            ex_res_valid = (c == 2); ex_res_taken = 1'b0;
            #1;
            total++; if (fe_obs[0] !== 1'b0 || id_bubble !== 1'b1) $display("FAIL jalr_wait_%0d: got we=%0b bub=%0b exp we=0 bub=1", c, fe_obs[0], id_bubble); else passed++;
            tick();
        end
        ex_res_valid = 1'b0;
        #1;
        total++; if (fe_obs !== C_ALU_WE) $display("FAIL jalr_redirect_alu: got %0h exp %0h", fe_obs, C_ALU_WE); else passed++;
        tick();
        #1;
        exp_bc += 4;
        total++; if (bubble_cnt !== 32'(exp_bc)) $display("FAIL jalr_cnt: got %0d exp %0d", bubble_cnt, exp_bc); else passed++;
        $display("test_jalr done, bubble_cnt=%0d", bubble_cnt);
    endtask

    task automatic test_stall_resolve();
        set_dec(1'b1, 1'b1, 1'b0, C_INC4_NOWE);
        tick();
        set_dec(1'b1, 1'b0, 1'b0, C_INC4_WE);
        be_stall = 1'b1; ex_res_valid = 1'b1; ex_res_taken = 1'b1;
        #1;
        total++; if (fe_obs[0] !== 1'b0 || id_bubble !== 1'b0) $display("FAIL stall_wait: got we=%0b bub=%0b exp we=0 bub=0", fe_obs[0], id_bubble); else passed++;
        tick();
        ex_res_valid = 1'b0; ex_res_taken = 1'b0;
        #1;
        total++; if (fe_obs !== C_ALU_NOWE || id_bubble !== 1'b0) $display("FAIL stall_redirect_held: got fe=%0h bub=%0b exp fe=%0h bub=0", fe_obs, id_bubble, C_ALU_NOWE); else passed++;
        tick();
        be_stall = 1'b0;
        #1;
        total++; if (fe_obs !== C_ALU_WE || id_bubble !== 1'b1) $display("FAIL stall_redirect_go: got fe=%0h bub=%0b exp fe=%0h bub=1", fe_obs, id_bubble, C_ALU_WE); else passed++;
        tick();
        #1;
        exp_bc += 1;
        total++; if (bubble_cnt !== 32'(exp_bc)) $display("FAIL stall_cnt: got %0d exp %0d", bubble_cnt, exp_bc); else passed++;
        $display("test_stall_resolve done, bubble_cnt=%0d", bubble_cnt);
    endtask

    task automatic test_branch_stall_defer();
        set_dec(1'b1, 1'b1, 1'b0, C_INC4_NOWE);
        be_stall = 1'b1;
        tick();
        be_stall = 1'b0;
        #1;
        total++; if (id_bubble !== 1'b0 || fe_obs !== C_INC4_NOWE) $display("FAIL defer_still_run: got bub=%0b fe=%0h exp bub=0 fe=%0h", id_bubble, fe_obs, C_INC4_NOWE); else passed++;
        tick();
        set_dec(1'b1, 1'b0, 1'b0, C_INC4_WE);
        ex_res_valid = 1'b1; ex_res_taken = 1'b1;
        #1;
        total++; if (id_bubble !== 1'b1 || fe_obs[0] !== 1'b0) $display("FAIL defer_wait: got bub=%0b we=%0b exp bub=1 we=0", id_bubble, fe_obs[0]); else passed++;
        tick();
        ex_res_valid = 1'b0; ex_res_taken = 1'b0;
        #1;
        total++; if (fe_obs !== C_ALU_WE) $display("FAIL defer_redirect: got %0h exp %0h", fe_obs, C_ALU_WE); else passed++;
        tick();
        #1;
        exp_bc += 2;
        total++; if (bubble_cnt !== 32'(exp_bc)) $display("FAIL defer_cnt: got %0d exp %0d", bubble_cnt, exp_bc); else passed++;
        $display("test_branch_stall_defer done, bubble_cnt=%0d", bubble_cnt);
    endtask

    task automatic test_redirect_imem_stall();
        set_dec(1'b1, 1'b1, 1'b0, C_INC4_NOWE);
        tick();
        set_dec(1'b1, 1'b0, 1'b0, C_INC4_WE);
        ex_res_valid = 1'b1; ex_res_taken = 1'b1;
        tick();
        ex_res_valid = 1'b0; ex_res_taken = 1'b0;
        imem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (fe_obs !== C_ALU_NOWE || id_bubble !== 1'b1) $display("FAIL imem_hold_%0d: got fe=%0h bub=%0b exp fe=%0h bub=1", c, fe_obs, id_bubble, C_ALU_NOWE); else passed++;
            tick();
        end
        imem_ready = 1'b1;
        #1;
        total++; if (fe_obs !== C_ALU_WE) $display("FAIL imem_go: got %0h exp %0h", fe_obs, C_ALU_WE); else passed++;
        tick();
        #1;
        exp_bc += 5;
        total++; if (id_bubble !== 1'b0 || fe_obs !== C_INC4_WE) $display("FAIL imem_run: got bub=%0b fe=%0h exp bub=0 fe=%0h", id_bubble, fe_obs, C_INC4_WE); else passed++;
        total++; if (bubble_cnt !== 32'(exp_bc)) $display("FAIL imem_cnt: got %0d exp %0d", bubble_cnt, exp_bc); else passed++;
        $display("test_redirect_imem_stall done, bubble_cnt=%0d", bubble_cnt);
    endtask

    task automatic test_reset_mid();
        set_dec(1'b1, 1'b1, 1'b0, C_INC4_NOWE);
        tick();
        set_dec(1'b1, 1'b0, 1'b0, C_INC4_WE);
        #1;
        total++; if (id_bubble !== 1'b1) $display("FAIL mid_wait_bubble: got %0b exp 1", id_bubble); else passed++;
        rst = 1'b1;
        #1;
        total++; if (fe_obs !== C_INIT || id_bubble !== 1'b1) $display("FAIL mid_rst_out: got fe=%0h bub=%0b exp fe=%0h bub=1", fe_obs, id_bubble, C_INIT); else passed++;
        total++; if (bubble_cnt !== 32'd0) $display("FAIL mid_rst_cnt: got %0d exp 0", bubble_cnt); else passed++;
        // A resolution arriving while reset is held must leave no trace.
        ex_res_valid = 1'b1; ex_res_taken = 1'b1;
        tick();
        ex_res_valid = 1'b0; ex_res_taken = 1'b0;
        rst = 1'b0;
        #1;
        total++; if (fe_obs !== C_START_WE) $display("FAIL mid_start: got %0h exp %0h", fe_obs, C_START_WE); else passed++;
        tick();
        #1;
        exp_bc = 1;
        total++; if (fe_obs !== C_INC4_WE || id_bubble !== 1'b0) $display("FAIL mid_run: got fe=%0h bub=%0b exp fe=%0h bub=0", fe_obs, id_bubble, C_INC4_WE); else passed++;
        total++; if (bubble_cnt !== 32'(exp_bc)) $display("FAIL mid_cnt: got %0d exp %0d", bubble_cnt, exp_bc); else passed++;
        $display("test_reset_mid done, bubble_cnt=%0d", bubble_cnt);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        exp_bc = 0;
        test_reset();
        test_branch_not_taken();
        test_jalr();
        test_stall_resolve();
        test_branch_stall_defer();
        test_redirect_imem_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
